// File: rtl/bf16_add_arbiter.sv
// Round-robin sequencer sharing one bfloat16 adder core among NREQ requesters.
// One operation in flight; a watchdog forces a NaN result if the core never answers.
module bf16_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [15:0]       rsp_sum,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [15:0]       add_a,
  output logic [15:0]       add_b,
  output logic              add_start,
  input  logic [15:0]       add_sum,
  input  logic              add_ready,
  output logic              busy,
  output logic              timeout_err
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);
  localparam logic [GW-1:0] G_LAST = GW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [15:0]     op_a_q, op_a_d;
  logic [15:0]     op_b_q, op_b_d;
  logic [15:0]     result_q, result_d;
  logic [WW-1:0]   wd_cnt_q, wd_cnt_d;

  logic            sel_found_s;
  logic [GW-1:0]   sel_idx_s;
  logic [GW:0]     cand_s;

  // Circular priority search starting at rr_ptr.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (cand_s >= (GW+1)'(NREQ)) begin
        cand_s = cand_s - (GW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!sel_found_s && req_valid[cand_s[GW-1:0]]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s[GW-1:0];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    result_d    = result_q;
    wd_cnt_d    = wd_cnt_q;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_sum     = 16'h0000;
    add_a       = 16'h0000;
    add_b       = 16'h0000;
    add_start   = 1'b0;
    busy        = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s) begin
          req_ready[sel_idx_s] = 1'b1;
          op_a_d  = req_a[{sel_idx_s, 4'b0000} +: 16];
          op_b_d  = req_b[{sel_idx_s, 4'b0000} +: 16];
          grant_d = sel_idx_s;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        busy      = 1'b1;
        add_start = 1'b1;
        add_a     = op_a_q;
        add_b     = op_b_q;
        wd_cnt_d  = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        busy  = 1'b1;
        add_a = op_a_q;
        add_b = op_b_q;
        // The first WAIT cycle masks a ready left over from the previous operation.
        if ((wd_cnt_q != '0) && add_ready) begin
          result_d = add_sum;
          state_d  = ST_RESP;
        end else if (wd_cnt_q == WD_MAX) begin
          result_d    = 16'hFFFF;
          timeout_err = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + WW'(1);
        end
      end
      ST_RESP: begin
        busy               = 1'b1;
        rsp_valid[grant_q] = 1'b1;
        rsp_sum            = result_q;
        if (rsp_ready[grant_q]) begin
          rr_ptr_d = (grant_q == G_LAST) ? '0 : grant_q + GW'(1);
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      op_a_q   <= 16'h0000;
      op_b_q   <= 16'h0000;
      result_q <= 16'h0000;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_bf16_add_arbiter.sv
// Directed plus randomized bench for bf16_add_arbiter with a behavioural adder-core model
// and a round-robin reference computed from pending requests and the last served requester.
module tb_bf16_add_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;
  localparam int W       = 16 * NREQ;

  logic            clock;
  logic            nreset;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0]    req_a, req_b;
  logic [15:0]     rsp_sum, add_a, add_b, add_sum;
  logic            add_start, add_ready, busy, timeout_err;

  int  n_assert   = 0;
  int  n_fail     = 0;
  int  core_lat   = 2;
  bit  core_hang  = 1'b0;
  bit  core_stale = 1'b0;
  int  mdl_ptr    = 0;
  logic [15:0] opa_m [NREQ];
  logic [15:0] opb_m [NREQ];

  bf16_add_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .nreset(nreset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready),
    .add_a(add_a), .add_b(add_b), .add_start(add_start),
    .add_sum(add_sum), .add_ready(add_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  function automatic logic [15:0] core_fn(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3F80 && b == 16'h4000) return 16'h4040;
    return a ^ {b[14:0], b[15]} ^ 16'h1234;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic bit is_set(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // First pending requester at or after the pointer, wrapping around.
  function automatic int model_grant(input logic [NREQ-1:0] pend, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (is_set(pend, (ptr + k) % NREQ)) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Adder core: answers core_lat cycles after start, holds the answer until the next start.
  initial begin : core_model
    int age;
    bit pending;
    logic [15:0] cap_a, cap_b;
    age = 0; pending = 1'b0; cap_a = 16'h0000; cap_b = 16'h0000;
    add_ready = 1'b0; add_sum = 16'h0000;
    forever begin
      @(posedge clock); #1;
      if (nreset !== 1'b1) begin
        add_ready = 1'b0; add_sum = 16'h0000; pending = 1'b0;
      end else if (add_start === 1'b1) begin
        cap_a = add_a; cap_b = add_b; age = 0; pending = 1'b1;
        if (core_stale) begin add_ready = 1'b1; add_sum = 16'hDEAD; end
        else begin add_ready = 1'b0; add_sum = 16'h0000; end
      end else if (pending) begin
        age++;
        if (!core_hang && age >= core_lat) begin
          add_ready = 1'b1; add_sum = core_fn(cap_a, cap_b);
        end else if (core_stale && age <= 1) begin
          add_ready = 1'b1; add_sum = 16'hDEAD;
        end else begin
          add_ready = 1'b0; add_sum = 16'h0000;
        end
      end
    end
  end

  task automatic step();
    @(negedge clock); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    logic [W-1:0] mask;
    mask = {{(W-16){1'b0}}, 16'hFFFF} << (16 * i);
    req_a = (req_a & ~mask) | ({{(W-16){1'b0}}, a} << (16 * i));
    req_b = (req_b & ~mask) | ({{(W-16){1'b0}}, b} << (16 * i));
    req_valid = req_valid | oh(i);
    opa_m[i] = a;
    opb_m[i] = b;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_sum"}, rsp_sum, 0);
    chk({tag, "_add_a"}, add_a, 0);
    chk({tag, "_add_b"}, add_b, 0);
    chk({tag, "_add_start"}, add_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // One full transaction for requester g, starting in IDLE with its request raised.
  task automatic txn(input int g, input int exp_idx, input logic [15:0] exp_sum,
                     input int exp_err, input int hold, input bit keep);
    int idx, starts, errs, err_at;
    #1;
    chk("grant", req_ready, oh(g));
    step();
    if (!keep) req_valid = req_valid & ~oh(g);
    chk("issue_start", add_start, 1);
    chk("issue_a", add_a, opa_m[g]);
    chk("issue_b", add_b, opb_m[g]);
    chk("issue_busy", busy, 1);
    chk("issue_no_ready", req_ready, 0);
    idx = 0; starts = 0; errs = 0; err_at = -1;
    while (rsp_valid == '0 && idx < 40) begin
      step();
      idx++;
      if (add_start === 1'b1) starts++;
      if (timeout_err === 1'b1) begin errs++; err_at = idx; end
    end
    chk("rsp_latency", idx, exp_idx);
    chk("rsp_valid", rsp_valid, oh(g));
    chk("rsp_sum", rsp_sum, exp_sum);
    chk("timeout_count", errs, exp_err);
    if (exp_err != 0) chk("timeout_cycle", err_at, TIMEOUT + 1);
    chk("extra_start", starts, 0);
    chk("resp_add_a", add_a, 0);
    rsp_ready = ~oh(g);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", rsp_valid, oh(g));
      chk("hold_sum", rsp_sum, exp_sum);
      chk("hold_start", add_start, 0);
      chk("hold_no_grant", req_ready, 0);
    end
    rsp_ready = oh(g);
    step();
    rsp_ready = '0;
    chk("accepted", rsp_valid, 0);
    mdl_ptr = (g + 1) % NREQ;
  endtask

  initial begin : main
    int g;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0; nreset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin opa_m[i] = 16'h0000; opb_m[i] = 16'h0000; end
    step(); step();
    check_quiet("reset");
    nreset = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Everyone requesting: strict rotation 0,1,2,3,0.
    core_lat = 2;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'($urandom), 16'($urandom));
    for (int n = 0; n < NREQ + 1; n++) begin
      g = model_grant(req_valid, mdl_ptr);
      txn(g, core_lat + 1, core_fn(opa_m[g], opb_m[g]), 0, 0, 1'b1);
    end
    req_valid = '0;

    // Single requester 0: 1.0 + 2.0.
    core_lat = 3;
    set_req(0, 16'h3F80, 16'h4000);
    g = model_grant(req_valid, mdl_ptr);
    txn(g, 4, 16'h4040, 0, 3, 1'b0);
    chk("single_idle_busy", busy, 0);

    // Backpressure on requester 2 while requester 0 waits.
    core_lat = 4;
    set_req(2, 16'($urandom), 16'($urandom));
    set_req(0, 16'($urandom), 16'($urandom));
    g = model_grant(req_valid, mdl_ptr);
    txn(g, 5, core_fn(opa_m[g], opb_m[g]), 0, 10, 1'b0);

    // Stale ready across ISSUE and first WAIT cycle.
    core_stale = 1'b1; core_lat = 2;
    g = model_grant(req_valid, mdl_ptr);
    txn(g, 3, core_fn(opa_m[g], opb_m[g]), 0, 1, 1'b0);
    core_stale = 1'b0;

    // Watchdog: core never answers.
    core_hang = 1'b1;
    set_req(1, 16'($urandom), 16'($urandom));
    g = model_grant(req_valid, mdl_ptr);
    txn(g, TIMEOUT + 2, 16'hFFFF, 1, 2, 1'b0);
    core_hang = 1'b0;

    // Ready arrives on the timeout cycle itself.
    core_lat = TIMEOUT + 1;
    set_req(3, 16'($urandom), 16'($urandom));
    g = model_grant(req_valid, mdl_ptr);
    txn(g, TIMEOUT + 2, core_fn(opa_m[g], opb_m[g]), 0, 0, 1'b0);

    // Random request patterns, latencies and backpressure.
    for (int it = 0; it < 12; it++) begin
      core_lat = int'($urandom_range(2, 6));
      for (int i = 0; i < NREQ; i++) begin
        if (!is_set(req_valid, i) && $urandom_range(0, 1) == 1)
          set_req(i, 16'($urandom), 16'($urandom));
      end
      if (req_valid == '0) set_req(int'($urandom_range(0, NREQ - 1)), 16'($urandom), 16'($urandom));
      g = model_grant(req_valid, mdl_ptr);
      txn(g, core_lat + 1, core_fn(opa_m[g], opb_m[g]), 0, int'($urandom_range(0, 3)), 1'b0);
    end
    for (int d = 0; d < NREQ; d++) begin
      if (req_valid != '0) begin
        g = model_grant(req_valid, mdl_ptr);
        txn(g, core_lat + 1, core_fn(opa_m[g], opb_m[g]), 0, 0, 1'b0);
      end
    end

    // Move the pointer to 2, then reset during WAIT.
    core_lat = 2;
    set_req(1, 16'($urandom), 16'($urandom));
    g = model_grant(req_valid, mdl_ptr);
    txn(g, 3, core_fn(opa_m[g], opb_m[g]), 0, 0, 1'b0);
    core_hang = 1'b1;
    set_req(2, 16'($urandom), 16'($urandom));
    #1;
    chk("pre_reset_grant", req_ready, oh(2));
    step();
    req_valid = '0;
    chk("pre_reset_start", add_start, 1);
    step(); step(); step();
    chk("pre_reset_busy", busy, 1);
    nreset = 1'b0;
    #1;
    check_quiet("mid_reset");
    step(); step();
    core_hang = 1'b0;
    nreset = 1'b1;
    mdl_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_reset_rsp", rsp_valid, 0);
      chk("post_reset_busy", busy, 0);
    end
    set_req(1, 16'($urandom), 16'($urandom));
    set_req(3, 16'($urandom), 16'($urandom));
    g = model_grant(req_valid, mdl_ptr);
    txn(g, 3, core_fn(opa_m[g], opb_m[g]), 0, 0, 1'b0);
    g = model_grant(req_valid, mdl_ptr);
    txn(g, 3, core_fn(opa_m[g], opb_m[g]), 0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bf16_add_arbiter.md
Name: bf16_add_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one bfloat16 adder core among NREQ requesters.
- Each requester issues an operand pair over a valid/ready handshake. The block drives the core's a/b/start inputs, waits for the core's ready, then returns the 16-bit sum to the owning requester over a valid/ready response channel.
- One operation is in flight at a time.
- A watchdog guards against a core that never signals ready.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 15, max cycles spent in WAIT before forcing a NaN result (>= 6).

Ports:
- clock  in  1  system clock, rising edge
- nreset  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operation request
- req_a  in  16*NREQ  operand A, requester i at [16i+15:16i]
- req_b  in  16*NREQ  operand B, same packing
- req_ready  out  NREQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i]
- rsp_valid  out  NREQ  one-hot result valid to the owning requester
- rsp_sum  out  16  result, shared bus
- rsp_ready  in  NREQ  per-requester result accept
- add_a  out  16  operand A to adder core
- add_b  out  16  operand B to adder core
- add_start  out  1  adder core start
- add_sum  in  16  adder core result
- add_ready  in  1  adder core result valid
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Clock/reset: one clock, `clock`. Reset `nreset` is asynchronous, active-low.
- Reset values: state=IDLE, rr_ptr=0, grant=0, op_a=op_b=0, result=0, wd_cnt=0. All outputs 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - g = first i with req_valid[i]=1, searching circularly from rr_ptr.
  - req_ready[g]=1 (combinational, only in IDLE, only for g). At most one req_ready bit high.
  - On the handshake: op_a<=req_a[g], op_b<=req_b[g], grant<=g, next=ISSUE.
  - With no req_valid, stay in IDLE. req_valid may drop without penalty.
- ISSUE:
  - add_start=1 for exactly this one cycle.
  - wd_cnt<=0, next=WAIT.
- add_a/add_b: driven from op_a/op_b in ISSUE and WAIT; 0 otherwise.
- WAIT:
  - wd_cnt increments each cycle.
  - add_ready is ignored while wd_cnt==0, which masks stale ready from the core.
  - When wd_cnt>=1 and add_ready=1: result<=add_sum, next=RESP.
  - When wd_cnt==TIMEOUT and add_ready=0: result<=16'hFFFF, timeout_err=1 for one cycle, next=RESP.
  - If add_ready and the timeout coincide, add_ready wins and there is no error.
- RESP:
  - rsp_valid[grant]=1. rsp_sum=result, held stable until accepted.
  - On rsp_ready[grant]: rr_ptr<=(grant+1) mod NREQ, next=IDLE.
  - rsp_ready on other bits is ignored.
- rsp_sum = 0 outside RESP.
- add_ready outside WAIT is ignored.
- Fairness: the granted requester becomes lowest priority after completion. rr_ptr updates only on response acceptance.
- Minimum latency, request handshake to rsp_valid: 3 cycles plus the core latency. Earliest next grant is the cycle after response acceptance.
- Reset mid-operation: everything returns to reset values immediately. The in-flight result is discarded and no rsp_valid is produced.
- busy=1 in ISSUE, WAIT, RESP.

Test Plan:
- Single requester 0: a=16'h3F80 (1.0), b=16'h4000 (2.0); core model returns 16'h4040 after 3 cycles -> exactly one add_start pulse; rsp_valid=4'b0001 with rsp_sum=16'h4040; held until rsp_ready[0]; busy low afterwards.
- All four req_valid held high, rsp_ready tied high -> grants in order 0,1,2,3,0; never two req_ready bits high; each requester receives its own sum.
- Backpressure: rsp_ready[2]=0 for 10 cycles after rsp_valid[2] -> rsp_valid and rsp_sum stable; no new grant; add_start stays 0.
- Stale ready: add_ready held 1 across the ISSUE cycle and the first WAIT cycle, with the core sum valid later -> result taken no earlier than the second WAIT cycle.
- Watchdog: core never asserts add_ready -> at wd_cnt==15, timeout_err pulses once; rsp_sum=16'hFFFF to the granted requester. With add_ready=1 on the same cycle -> add_sum returned and no error.
- Assert nreset in WAIT -> all outputs 0 asynchronously; after release, a new request from requester 3 is served normally with rr_ptr=0.
